// File: rtl/tune_ctrl.sv
// Front-panel tuning controller: debounced buttons step the NCO phase increment with hold-repeat, acceleration and clamping.
// Outputs register one CLK after a step or load; no backpressure, buttons and load are sampled every cycle.
module tune_ctrl #(
  parameter int unsigned        PHASE_W        = 40,
  parameter int unsigned        TICK_DIV       = 100000,
  parameter int unsigned        DEBOUNCE_TICKS = 20,
  parameter int unsigned        REPEAT_DELAY   = 400,
  parameter int unsigned        REPEAT_RATE    = 100,
  parameter int unsigned        ACCEL_COUNT    = 8,
  parameter int unsigned        ACCEL_SHIFT    = 3,
  parameter logic [PHASE_W-1:0] FINE_STEP      = 40'h110c6f7,
  parameter logic [PHASE_W-1:0] COARSE_STEP    = 40'h1346dc5d,
  parameter logic [PHASE_W-1:0] INIT_PHASE     = 40'h2656abde3,
  parameter logic [PHASE_W-1:0] MIN_PHASE      = 40'h17f62b6ae,
  parameter logic [PHASE_W-1:0] MAX_PHASE      = 40'h47ae147ae1
) (
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               btn_fine_up,
  input  logic               btn_fine_dn,
  input  logic               btn_coarse_up,
  input  logic               btn_coarse_dn,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               changed,
  output logic               at_limit
);

  localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW   = $clog2(RMAX + 1);
  localparam int unsigned AW   = $clog2(ACCEL_COUNT + 1);
  localparam int unsigned IW   = PHASE_W + ACCEL_SHIFT + 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [AW-1:0] ACCEL_SAT  = AW'(ACCEL_COUNT);
  localparam logic          LIMIT_INIT = (INIT_PHASE == MIN_PHASE) || (INIT_PHASE == MAX_PHASE);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;
  typedef enum logic [2:0] {ACT_NONE, ACT_FINE_UP, ACT_FINE_DN, ACT_COARSE_UP, ACT_COARSE_DN} act_e;

  logic [TW-1:0]         div_q, div_d;
  logic                  tick;
  logic [3:0]            btn_raw;
  logic [3:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]            db_q, db_d;
  logic [3:0][DW-1:0]    dbc_q, dbc_d;
  state_e                state_q, state_d;
  act_e                  act, act_q, act_d;
  logic [CW-1:0]         tcnt_q, tcnt_d;
  logic [AW-1:0]         rep_q, rep_d;
  logic                  step, accel, up, coarse;
  logic [IW-1:0]         base_w, step_w, sum_w, floor_w;
  logic [PHASE_W-1:0]    stepped, load_clamped;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic                  changed_q, changed_d, at_limit_q, at_limit_d;

  assign btn_raw = {btn_coarse_dn, btn_coarse_up, btn_fine_dn, btn_fine_up};

  // Tick prescaler, synchroniser and per-button debounce.
  always_comb begin
    tick    = (div_q == TICK_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    dbc_d   = dbc_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        dbc_d[i] = '0;
      end else if (tick) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i]  = ~db_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  // Coarse outranks fine; an up+down pair cancels only its own class.
  always_comb begin
    act = ACT_NONE;
    if (db_q[2] ^ db_q[3]) begin
      act = db_q[2] ? ACT_COARSE_UP : ACT_COARSE_DN;
    end else if (db_q[0] ^ db_q[1]) begin
      act = db_q[0] ? ACT_FINE_UP : ACT_FINE_DN;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    tcnt_d  = tcnt_q;
    rep_d   = rep_q;
    step    = 1'b0;
    accel   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (act != ACT_NONE) begin
          step    = 1'b1;
          act_d   = act;
          tcnt_d  = '0;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (act != act_q) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else if (tick) begin
          if (tcnt_q == DELAY_LAST) begin
            step    = 1'b1;
            tcnt_d  = '0;
            rep_d   = AW'(1);
            state_d = S_REPEAT;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        if (act != act_q) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          rep_d   = '0;
        end else if (tick) begin
          if (tcnt_q == RATE_LAST) begin
            step   = 1'b1;
            accel  = (rep_q >= ACCEL_SAT);
            tcnt_d = '0;
            if (rep_q != ACCEL_SAT) rep_d = rep_q + 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wide intermediates hold the accelerated step and the sum without wrapping before the clamp.
  always_comb begin
    coarse  = (act == ACT_COARSE_UP) || (act == ACT_COARSE_DN);
    up      = (act == ACT_FINE_UP) || (act == ACT_COARSE_UP);
    base_w  = IW'(phase_q);
    step_w  = IW'(coarse ? COARSE_STEP : FINE_STEP);
    if (accel) step_w = step_w << ACCEL_SHIFT;
    sum_w   = base_w + step_w;
    floor_w = IW'(MIN_PHASE) + step_w;
    if (up) begin
      stepped = (sum_w > IW'(MAX_PHASE)) ? MAX_PHASE : PHASE_W'(sum_w);
    end else begin
      stepped = (base_w < floor_w) ? MIN_PHASE : PHASE_W'(base_w - step_w);
    end

    if (load_val < MIN_PHASE) begin
      load_clamped = MIN_PHASE;
    end else if (load_val > MAX_PHASE) begin
      load_clamped = MAX_PHASE;
    end else begin
      load_clamped = load_val;
    end

    phase_d = phase_q;
    if (load) begin
      phase_d = load_clamped;
    end else if (step) begin
      phase_d = stepped;
    end
    changed_d  = (phase_d != phase_q);
    at_limit_d = (phase_d == MIN_PHASE) || (phase_d == MAX_PHASE);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      div_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      dbc_q      <= '0;
      state_q    <= S_IDLE;
      act_q      <= ACT_NONE;
      tcnt_q     <= '0;
      rep_q      <= '0;
      phase_q    <= INIT_PHASE;
      changed_q  <= 1'b0;
      at_limit_q <= LIMIT_INIT;
    end else begin
      div_q      <= div_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      dbc_q      <= dbc_d;
      state_q    <= state_d;
      act_q      <= act_d;
      tcnt_q     <= tcnt_d;
      rep_q      <= rep_d;
      phase_q    <= phase_d;
      changed_q  <= changed_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign phase_inc = phase_q;
  assign changed   = changed_q;
  assign at_limit  = at_limit_q;

endmodule

// File: tb/tb_tune_ctrl.sv
// Bench for tune_ctrl: abstract per-cycle model compared every cycle, plus hand-computed checkpoints.
module tb_tune_ctrl;

  localparam int TD = 4;
  localparam int DT = 3;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam int AC = 2;
  localparam int AS = 3;
  localparam logic [39:0] FINE_P   = 40'h110c6f7;
  localparam logic [39:0] COARSE_P = 40'h1346dc5d;
  localparam logic [39:0] INIT_P   = 40'h2656abde3;
  localparam logic [39:0] MIN_P    = 40'h17f62b6ae;
  localparam logic [39:0] MAX_P    = 40'h47ae147ae1;
  localparam int A_NONE = 0, A_FU = 1, A_FD = 2, A_CU = 3, A_CD = 4;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        btn_fine_up, btn_fine_dn, btn_coarse_up, btn_coarse_dn;
  logic        load;
  logic [39:0] load_val;
  logic [39:0] phase_inc;
  logic        changed, at_limit;

  tune_ctrl #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .ACCEL_COUNT(AC), .ACCEL_SHIFT(AS)
  ) dut (
    .CLK(CLK), .RSTb(RSTb),
    .btn_fine_up(btn_fine_up), .btn_fine_dn(btn_fine_dn),
    .btn_coarse_up(btn_coarse_up), .btn_coarse_dn(btn_coarse_dn),
    .load(load), .load_val(load_val),
    .phase_inc(phase_inc), .changed(changed), .at_limit(at_limit)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  int tb_cyc = 0;
  bit chk_en = 1'b0;
  logic [39:0] pq[$];
  int          cq[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: ticks from a cycle count, sync as a 2-deep copy, repeat schedule from
  // the tick count since the press (step n at RD + (n-2)*RR ticks).
  int          m_cyc;
  bit [3:0]    m_s1, m_s2, m_db;
  int          m_dbn[4];
  int          m_held, m_ticks, m_n, m_act;
  bit          m_tick, m_stp, m_acc, m_collide;
  logic [39:0] m_phase, m_nxt;
  bit          m_changed, m_at_limit;

  function automatic int act_of(input bit [3:0] db);
    if (db[2] ^ db[3]) return db[2] ? A_CU : A_CD;
    if (db[0] ^ db[1]) return db[0] ? A_FU : A_FD;
    return A_NONE;
  endfunction

  function automatic logic [39:0] apply(input logic [39:0] p, input int a, input bit acc);
    logic [63:0] s, r;
    s = 64'((a == A_CU || a == A_CD) ? COARSE_P : FINE_P);
    if (acc) s = s << AS;
    if (a == A_FU || a == A_CU) r = (64'(p) + s > 64'(MAX_P)) ? 64'(MAX_P) : 64'(p) + s;
    else                        r = (64'(p) < 64'(MIN_P) + s) ? 64'(MIN_P) : 64'(p) - s;
    return r[39:0];
  endfunction

  function automatic logic [39:0] clamp(input logic [39:0] v);
    if (v < MIN_P) return MIN_P;
    if (v > MAX_P) return MAX_P;
    return v;
  endfunction

  always @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      m_cyc = 0; m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int i = 0; i < 4; i++) m_dbn[i] = 0;
      m_held = A_NONE; m_ticks = 0; m_n = 0; m_collide = 1'b0;
      m_phase = INIT_P; m_changed = 1'b0;
      m_at_limit = (INIT_P == MIN_P) || (INIT_P == MAX_P);
    end else begin
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_act = act_of(m_db);
      m_stp = 1'b0;
      m_acc = 1'b0;
      if (m_held == A_NONE) begin
        if (m_act != A_NONE) begin
          m_stp = 1'b1; m_held = m_act; m_ticks = 0; m_n = 1;
        end
      end else if (m_act != m_held) begin
        m_held = A_NONE;
      end else if (m_tick) begin
        m_ticks++;
        if (m_ticks == RD + (m_n - 1) * RR) begin
          m_stp = 1'b1;
          m_acc = (m_n + 1 >= AC + 2);
          m_n++;
        end
      end
      m_collide = load && m_stp;
      m_nxt = m_phase;
      if (load)       m_nxt = clamp(load_val);
      else if (m_stp) m_nxt = apply(m_phase, m_act, m_acc);
      m_changed  = (m_nxt != m_phase);
      m_phase    = m_nxt;
      m_at_limit = (m_nxt == MIN_P) || (m_nxt == MAX_P);
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_db[i]) m_dbn[i] = 0;
        else if (m_tick) begin
          m_dbn[i]++;
          if (m_dbn[i] == DT) begin
            m_db[i] = !m_db[i];
            m_dbn[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_coarse_dn, btn_coarse_up, btn_fine_dn, btn_fine_up};
    end
  end

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      check("cyc_phase_inc", 64'(phase_inc), 64'(m_phase));
      check("cyc_changed", 64'(changed), 64'(m_changed));
      check("cyc_at_limit", 64'(at_limit), 64'(m_at_limit));
      if (changed) begin
        n_pulse++;
        pq.push_back(phase_inc);
        cq.push_back(tb_cyc);
      end
    end
    tb_cyc++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_load(input logic [39:0] v);
    load = 1'b1;
    load_val = v;
    @(negedge CLK);
    load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] prev;
    int guard;
    RSTb = 1'b1; load = 1'b0; load_val = '0;
    btn_fine_up = 0; btn_fine_dn = 0; btn_coarse_up = 0; btn_coarse_dn = 0;
    #2 RSTb = 1'b0;
    #1 chk_en = 1'b1;
    #1;
    check("rst_phase", 64'(phase_inc), 64'h2656abde3);
    check("rst_changed", 64'(changed), 64'd0);
    check("rst_at_limit", 64'(at_limit), 64'd0);
    cycles(3);
    RSTb = 1'b1;
    cycles(4);
    check("idle_phase", 64'(phase_inc), 64'h2656abde3);

    // Glitch shorter than the debounce window, then a short real press.
    btn_fine_up = 1; cycles(2 * TD); btn_fine_up = 0; cycles(6 * TD);
    check("glitch_phase", 64'(phase_inc), 64'h2656abde3);
    n_pulse = 0;
    btn_fine_up = 1; cycles(4 * TD); btn_fine_up = 0; cycles(8 * TD);
    check("fine_one_step", 64'(phase_inc), 64'h2667b84da);
    check("fine_one_pulse", 64'(n_pulse), 64'd1);

    // Long coarse hold: step sizes and spacing of the first six steps.
    pq.delete(); cq.delete(); n_pulse = 0;
    btn_coarse_up = 1; cycles(30 * TD); btn_coarse_up = 0; cycles(8 * TD);
    check("hold_steps_ge6", 64'(n_pulse >= 6), 64'd1);
    prev = 40'h2667b84da;
    for (int k = 0; k < 6 && k < pq.size(); k++) begin
      check($sformatf("hold_delta%0d", k), 64'(pq[k] - prev),
            (k < 3) ? 64'h1346dc5d : 64'h9a36e2e8);
      if (k > 0) check($sformatf("hold_gap%0d", k), 64'(cq[k] - cq[k-1]), (k == 1) ? 64'd19 : 64'd8);
      prev = pq[k];
    end

    // Coarse down into the lower clamp.
    do_load(MIN_P + COARSE_P + 40'd5); cycles(2);
    n_pulse = 0;
    btn_coarse_dn = 1; cycles(20 * TD); btn_coarse_dn = 0; cycles(8 * TD);
    check("min_clamp", 64'(phase_inc), 64'h17f62b6ae);
    check("min_at_limit", 64'(at_limit), 64'd1);
    check("min_pulses", 64'(n_pulse), 64'd2);

    // Cancelled fine pair, coarse overriding it, then coarse released.
    do_load(INIT_P); cycles(2);
    n_pulse = 0;
    btn_fine_up = 1; btn_fine_dn = 1; cycles(8 * TD);
    check("pair_no_step", 64'(phase_inc), 64'h2656abde3);
    check("pair_no_pulse", 64'(n_pulse), 64'd0);
    btn_coarse_up = 1; cycles(4 * TD); btn_coarse_up = 0;
    check("pair_coarse_step", 64'(phase_inc), 64'(INIT_P + COARSE_P));
    cycles(10 * TD);
    check("pair_release_hold", 64'(phase_inc), 64'(INIT_P + COARSE_P));
    check("pair_pulses", 64'(n_pulse), 64'd1);
    btn_fine_up = 0; btn_fine_dn = 0; cycles(8 * TD);

    // Over-range load on the same cycle as the delayed repeat step.
    btn_fine_up = 1;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!m_changed && guard < 400);
    check("press_seen", 64'(guard < 400), 64'd1);
    cycles(18);
    load_val = 40'hffffffffff; load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
    check("load_collides_step", 64'(m_collide), 64'd1);
    check("load_max", 64'(phase_inc), 64'h47ae147ae1);
    check("load_changed", 64'(changed), 64'd1);
    check("load_at_limit", 64'(at_limit), 64'd1);
    cycles(6 * TD);
    check("max_hold", 64'(phase_inc), 64'h47ae147ae1);
    btn_fine_up = 0; cycles(8 * TD);

    // Reset in the middle of a held press.
    btn_coarse_up = 1; cycles(10 * TD);
    #1 RSTb = 1'b0;
    #1;
    check("midrst_phase", 64'(phase_inc), 64'h2656abde3);
    check("midrst_changed", 64'(changed), 64'd0);
    check("midrst_at_limit", 64'(at_limit), 64'd0);
    cycles(3);
    RSTb = 1'b1;
    cycles(2 * TD);
    check("midrst_no_early", 64'(phase_inc), 64'h2656abde3);
    cycles(8 * TD);
    btn_coarse_up = 0; cycles(8 * TD);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
